prog_fill_engine: RTL and testbench

Memory-side responder for the program cache refill request (is_req / req_addr).
- Captures an 18-bit top address and fetches the matching 16 KiB region from word-wide program memory: 256 lines of 512 bits.
- Assembles each line and pushes it, tagged with its 8-bit line index, into the line FIFO that the cache drains.
- Sits between the program cache fill port and the memory arbiter.

---
 rtl/prog_cache_pkg.sv | 31 +++
 rtl/prog_line_assembler.sv | 49 ++++
 rtl/prog_fill_engine.sv | 165 ++++++++++++++++
 tb/tb_prog_fill_engine.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_cache_pkg.sv
// Shared definitions for the program cache refill path: geometry of the
// cacheable region, the fill FSM state type and the word address builder.
package prog_cache_pkg;

  localparam int TOP_ADDR_WIDTH    = 18;
  localparam int LINE_INDEX_WIDTH  = 8;
  localparam int LINE_WIDTH        = 512;
  localparam int WORD_WIDTH        = 32;
  localparam int ADDR_WIDTH        = 32;
  localparam int WORDS_PER_LINE    = LINE_WIDTH / WORD_WIDTH;
  localparam int WORD_SEL_WIDTH    = $clog2(WORDS_PER_LINE);
  localparam int WORD_CNT_WIDTH    = WORD_SEL_WIDTH + 1;
  localparam int WORD_OFFSET_WIDTH = $clog2(WORD_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PUSH,
    DONE
  } fill_state_t;

  // Byte address of one word: tag, line index, word slot, then a zero byte offset.
  function automatic logic [ADDR_WIDTH-1:0] make_word_addr(
    input logic [TOP_ADDR_WIDTH-1:0]   tag,
    input logic [LINE_INDEX_WIDTH-1:0] idx,
    input logic [WORD_SEL_WIDTH-1:0]   slot
  );
    return {tag, idx, slot, {WORD_OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/prog_line_assembler.sv
// Collects read-data words returned by program memory into one cache line.
// Words arrive in request order, so the receive counter doubles as the slot
// pointer. A return is only accepted while fewer words have been received
// than issued; anything else is a stray beat and is dropped.
module prog_line_assembler
  import prog_cache_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clear,
  input  logic                      i_enable,
  input  logic                      i_rvalid,
  input  logic [WORD_WIDTH-1:0]     i_rdata,
  input  logic [WORD_CNT_WIDTH-1:0] i_issue_cnt,
  output logic                      o_last_beat,
  output logic                      o_line_full,
  output logic [LINE_WIDTH-1:0]     o_line
);

  logic [WORD_CNT_WIDTH-1:0] r_recv_cnt;
  logic [LINE_WIDTH-1:0]     r_line;
  logic                      w_accept;

  assign w_accept    = i_enable & i_rvalid & (r_recv_cnt < i_issue_cnt);
  assign o_last_beat = w_accept & (r_recv_cnt == WORD_CNT_WIDTH'(WORDS_PER_LINE - 1));
  assign o_line_full = (r_recv_cnt == WORD_CNT_WIDTH'(WORDS_PER_LINE));
  assign o_line      = r_line;

  // Count accepted words; cleared between lines and whenever the engine is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_recv_cnt <= '0;
    end else if (i_clear) begin
      r_recv_cnt <= '0;
    end else if (w_accept) begin
      r_recv_cnt <= r_recv_cnt + 1'b1;
    end
  end

  // Drop each accepted word into its slot; word n lands in bits [32n+31:32n].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line <= '0;
    end else if (w_accept) begin
      r_line[r_recv_cnt[WORD_SEL_WIDTH-1:0] * WORD_WIDTH +: WORD_WIDTH] <= i_rdata;
    end
  end

endmodule

// File: rtl/prog_fill_engine.sv
// Memory-side responder for program cache refills. On a request it captures
// the region tag, reads the region's 256 lines word by word from program
// memory and pushes each assembled line, tagged with its index, into the
// line FIFO feeding the cache.
// Optional build macro: PROG_FILL_CRIT_FIRST_EN adds the req_line input so the
// fill starts at the requested line and wraps round the region.
module prog_fill_engine
  import prog_cache_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        is_req,
  input  logic [TOP_ADDR_WIDTH-1:0]   req_addr,
`ifdef PROG_FILL_CRIT_FIRST_EN
  input  logic [LINE_INDEX_WIDTH-1:0] req_line,
`endif
  output logic                        req_ack,
  output logic                        busy,
  output logic                        fill_done,
  output logic                        mem_req,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic                        mem_ready,
  input  logic                        mem_rvalid,
  input  logic [WORD_WIDTH-1:0]       mem_rdata,
  output logic                        fifo_wr_en,
  output logic [LINE_INDEX_WIDTH-1:0] fifo_wr_addr,
  output logic [LINE_WIDTH-1:0]       fifo_wr_line,
  input  logic                        fifo_full
);

  fill_state_t                 r_state;
  fill_state_t                 w_next_state;
  logic [TOP_ADDR_WIDTH-1:0]   r_tag;
  logic [LINE_INDEX_WIDTH-1:0] r_line_idx;
  logic [WORD_CNT_WIDTH-1:0]   r_issue_cnt;

  logic                        w_capture;
  logic                        w_issue_open;
  logic                        w_issue;
  logic                        w_push;
  logic                        w_last_line;
  logic                        w_last_beat;
  logic                        w_line_full;
  logic                        w_asm_clear;
  logic [LINE_WIDTH-1:0]       w_line;
  logic [LINE_INDEX_WIDTH-1:0] w_start_line;

`ifdef PROG_FILL_CRIT_FIRST_EN
  logic [LINE_INDEX_WIDTH-1:0] r_first_line;

  // Remember where the fill started so the wrap-around end can be detected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first_line <= '0;
    end else if (w_capture) begin
      r_first_line <= req_line;
    end
  end

  assign w_start_line = req_line;
  assign w_last_line  = (LINE_INDEX_WIDTH'(r_line_idx + 1'b1) == r_first_line);
`else
  assign w_start_line = '0;
  assign w_last_line  = (r_line_idx == {LINE_INDEX_WIDTH{1'b1}});
`endif

  assign w_capture    = (r_state == IDLE) & is_req;
  assign w_issue_open = (r_state == FILL) & (r_issue_cnt < WORD_CNT_WIDTH'(WORDS_PER_LINE));
  assign w_issue      = w_issue_open & mem_ready;
  assign w_push       = (r_state == PUSH) & w_line_full & ~fifo_full;
  assign w_asm_clear  = (r_state == IDLE) | w_push;

  prog_line_assembler u_assembler (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_asm_clear),
    .i_enable    (r_state == FILL),
    .i_rvalid    (mem_rvalid),
    .i_rdata     (mem_rdata),
    .i_issue_cnt (r_issue_cnt),
    .o_last_beat (w_last_beat),
    .o_line_full (w_line_full),
    .o_line      (w_line)
  );

  // State register; reset anywhere abandons the fill without pushing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and all outward signals, zero unless the state drives them.
  always_comb begin
    w_next_state = r_state;
    req_ack      = 1'b0;
    busy         = 1'b0;
    fill_done    = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_addr = '0;
    fifo_wr_line = '0;
    case (r_state)
      IDLE: begin
        if (is_req) begin
          req_ack      = 1'b1;
          w_next_state = FILL;
        end
      end
      FILL: begin
        busy    = 1'b1;
        mem_req = w_issue_open;
        if (w_issue_open) begin
          mem_addr = make_word_addr(r_tag, r_line_idx, r_issue_cnt[WORD_SEL_WIDTH-1:0]);
        end
        if (w_last_beat) begin
          w_next_state = PUSH;
        end
      end
      PUSH: begin
        busy         = 1'b1;
        fifo_wr_en   = w_push;
        fifo_wr_addr = r_line_idx;
        fifo_wr_line = w_line;
        if (w_push) begin
          w_next_state = w_last_line ? DONE : FILL;
        end
      end
      DONE: begin
        busy         = 1'b1;
        fill_done    = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Tag is sampled only at capture; line index steps after each push but the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag      <= '0;
      r_line_idx <= '0;
    end else if (w_capture) begin
      r_tag      <= req_addr;
      r_line_idx <= w_start_line;
    end else if (w_push && !w_last_line) begin
      r_line_idx <= r_line_idx + 1'b1;
    end
  end

  // Issue counter: one word per accepted beat, restarted for every line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_cnt <= '0;
    end else if (w_capture || w_push) begin
      r_issue_cnt <= '0;
    end else if (w_issue) begin
      r_issue_cnt <= r_issue_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_fill_engine.sv
// Bench for prog_fill_engine: a memory model that returns word = address,
// a FIFO-side monitor that rebuilds every expected line from the tag and
// index, a table of whole-region fills, and hand sequences for reset,
// request-while-busy and (with PROG_FILL_CRIT_FIRST_EN) critical-line-first.
module tb_prog_fill_engine;
  import prog_cache_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         is_req = 1'b0;
  logic [17:0]  req_addr = '0;
`ifdef PROG_FILL_CRIT_FIRST_EN
  logic [7:0]   req_line = '0;
`endif
  logic         req_ack, busy, fill_done, mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready = 1'b1;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         fifo_wr_en;
  logic [7:0]   fifo_wr_addr;
  logic [511:0] fifo_wr_line;
  logic         fifo_full = 1'b0;

  int totalChecks = 0;
  int badChecks = 0;
  int cyc = 0;

  bit          monEn = 1'b0;
  logic [17:0] expTag = '0;
  logic [7:0]  expIssueLine = '0;
  logic [7:0]  expPushLine = '0;
  logic [7:0]  lastPushLine = '0;
  int          expIssueWord = 0;
  int          pushCount = 0;
  int          doneCount = 0;
  logic [31:0] firstW0 = '0;
  logic [31:0] firstW15 = '0;
  bit          readyToggle = 1'b0;
  int          rdelay = 1;
  int          bpLine = -1;
  bit          bpDone = 1'b0;
  int          heldCycles = 0;
  bit          expectPushNow = 1'b0;
  logic [31:0] pendAddr[$];
  int          pendDue[$];

  typedef struct {
    logic [17:0] tag;
    bit          readyToggle;
    int          rdelay;
    int          bpLine;
    logic [31:0] expW0;
    logic [31:0] expW15;
    int          expPushes;
    logic [7:0]  expLast;
  } vec_t;

  vec_t vecs[3];

  prog_fill_engine dut (
    .clk          (clk),
    .rst          (rst),
    .is_req       (is_req),
    .req_addr     (req_addr),
`ifdef PROG_FILL_CRIT_FIRST_EN
    .req_line     (req_line),
`endif
    .req_ack      (req_ack),
    .busy         (busy),
    .fill_done    (fill_done),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_addr (fifo_wr_addr),
    .fifo_wr_line (fifo_wr_line),
    .fifo_full    (fifo_full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  function automatic logic [511:0] expLine(input logic [17:0] tag, input logic [7:0] idx);
    logic [511:0] l;
    l = '0;
    for (int w = 0; w < 16; w++) begin
      l[w*32 +: 32] = {tag, idx, 4'(w), 2'b00};
    end
    return l;
  endfunction

  // Memory model: ready pattern plus in-order read returns after rdelay cycles.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    mem_ready = readyToggle ? (cyc % 2 == 0) : 1'b1;
    if (pendDue.size() > 0 && pendDue[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pendAddr.pop_front();
      void'(pendDue.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
  end

  // FIFO backpressure: hold full from the start of line bpLine until 10 blocked push cycles.
  always @(posedge clk) begin
    #1;
    if (bpLine >= 0 && !bpDone) begin
      if (!fifo_full && pushCount == bpLine) begin
        fifo_full = 1'b1;
      end else if (fifo_full && heldCycles >= 10) begin
        fifo_full     = 1'b0;
        expectPushNow = 1'b1;
        bpDone        = 1'b1;
      end
    end
  end

  // Monitor: issue order, pushed lines, backpressure behaviour and done pulses.
  always @(negedge clk) begin
    if (monEn && !rst) begin
      if (mem_req && mem_ready) begin
        checkOutput("memAddr", 512'(mem_addr), 512'({expTag, expIssueLine, 4'(expIssueWord), 2'b00}));
        pendAddr.push_back(mem_addr);
        pendDue.push_back(cyc + rdelay);
        expIssueWord++;
        if (expIssueWord == 16) begin
          expIssueWord = 0;
          expIssueLine++;
        end
      end
      if (fifo_full && bpLine >= 0 && fifo_wr_addr == 8'(bpLine)) begin
        heldCycles++;
        checkOutput("bpWrEnLow", 512'(fifo_wr_en), 512'(0));
        checkOutput("bpLineStable", fifo_wr_line, expLine(expTag, 8'(bpLine)));
      end
      if (expectPushNow) begin
        checkOutput("bpPushOnRelease", 512'(fifo_wr_en), 512'(1));
        expectPushNow = 1'b0;
      end
      if (fifo_wr_en) begin
        checkOutput("pushIdx", 512'(fifo_wr_addr), 512'(expPushLine));
        checkOutput("pushLine", fifo_wr_line, expLine(expTag, expPushLine));
        if (pushCount == 0) begin
          firstW0  = fifo_wr_line[31:0];
          firstW15 = fifo_wr_line[511:480];
        end
        lastPushLine = fifo_wr_addr;
        expPushLine++;
        pushCount++;
      end
      if (fill_done) doneCount++;
    end
  end

  task automatic resetModel(input logic [17:0] tag, input logic [7:0] first);
    expTag        = tag;
    expIssueLine  = first;
    expIssueWord  = 0;
    expPushLine   = first;
    pushCount     = 0;
    doneCount     = 0;
    heldCycles    = 0;
    expectPushNow = 1'b0;
  endtask

  task automatic applyStimulus(input logic [17:0] tag, input logic [7:0] first);
    @(posedge clk); #1;
    resetModel(tag, first);
    is_req   = 1'b1;
    req_addr = tag;
`ifdef PROG_FILL_CRIT_FIRST_EN
    req_line = first;
`endif
    @(negedge clk);
    checkOutput("reqAck", 512'(req_ack), 512'(1));
    checkOutput("idleNotBusy", 512'(busy), 512'(0));
  endtask

  task automatic waitFillDone(input int budget);
    int n = 0;
    while (doneCount == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (doneCount == 0) checkOutput("fillDoneTimeout", 512'(0), 512'(1));
  endtask

  task automatic checkResetOutputs();
    checkOutput("rstReqAck", 512'(req_ack), 512'(0));
    checkOutput("rstBusy", 512'(busy), 512'(0));
    checkOutput("rstFillDone", 512'(fill_done), 512'(0));
    checkOutput("rstMemReq", 512'(mem_req), 512'(0));
    checkOutput("rstMemAddr", 512'(mem_addr), 512'(0));
    checkOutput("rstWrEn", 512'(fifo_wr_en), 512'(0));
    checkOutput("rstWrAddr", 512'(fifo_wr_addr), 512'(0));
    checkOutput("rstWrLine", fifo_wr_line, 512'(0));
  endtask

  initial begin
    int n;
    vecs[0] = '{tag: 18'h00001, readyToggle: 1'b0, rdelay: 1, bpLine: -1,
                expW0: 32'h00004000, expW15: 32'h0000403C, expPushes: 256, expLast: 8'hFF};
    vecs[1] = '{tag: 18'h2A5F3, readyToggle: 1'b0, rdelay: 1, bpLine: 7,
                expW0: 32'hA97CC000, expW15: 32'hA97CC03C, expPushes: 256, expLast: 8'hFF};
    vecs[2] = '{tag: 18'h00ABC, readyToggle: 1'b1, rdelay: 3, bpLine: -1,
                expW0: 32'h02AF0000, expW15: 32'h02AF003C, expPushes: 256, expLast: 8'hFF};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetOutputs();
    monEn = 1'b1;

    for (int i = 0; i < 3; i++) begin
      readyToggle = vecs[i].readyToggle;
      rdelay      = vecs[i].rdelay;
      bpDone      = 1'b0;
      bpLine      = vecs[i].bpLine;
      applyStimulus(vecs[i].tag, 8'h00);
      @(posedge clk); #1;
      is_req = 1'b0;
      @(negedge clk);
      checkOutput("busyDuringFill", 512'(busy), 512'(1));
      checkOutput("reqAckSingle", 512'(req_ack), 512'(0));
      waitFillDone(20000);
      @(negedge clk);
      checkOutput("idleAfterDone", 512'(busy), 512'(0));
      checkOutput("doneIsPulse", 512'(fill_done), 512'(0));
      checkOutput("pushCount", 512'(pushCount), 512'(vecs[i].expPushes));
      checkOutput("doneCount", 512'(doneCount), 512'(1));
      checkOutput("line0Word0", 512'(firstW0), 512'(vecs[i].expW0));
      checkOutput("line0Word15", 512'(firstW15), 512'(vecs[i].expW15));
      checkOutput("lastIdx", 512'(lastPushLine), 512'(vecs[i].expLast));
      if (vecs[i].bpLine >= 0) checkOutput("bpHeld", 512'(heldCycles >= 10), 512'(1));
      bpLine = -1;
    end

    // Reset in the middle of line 100, just after word 5 is accepted.
    readyToggle = 1'b0;
    rdelay      = 1;
    applyStimulus(18'h15555, 8'h00);
    @(posedge clk); #1;
    is_req = 1'b0;
    n = 0;
    while (!(expIssueLine == 8'd100 && expIssueWord >= 6) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reachLine100", 512'(expIssueLine == 8'd100 && expIssueWord >= 6), 512'(1));
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("pushesBeforeReset", 512'(pushCount), 512'(100));
    checkOutput("noDoneAfterReset", 512'(doneCount), 512'(0));
    checkOutput("idleAfterReset", 512'(busy), 512'(0));

    // Fresh fill at the top tag; req_addr changes and is_req stays high while busy.
    applyStimulus(18'h3FFFF, 8'h00);
    @(posedge clk); #1;
    req_addr = 18'h12345;
    waitFillDone(20000);
    @(negedge clk);
    checkOutput("recaptureAck", 512'(req_ack), 512'(1));
    checkOutput("topPushCount", 512'(pushCount), 512'(256));
    checkOutput("topLine0Word0", 512'(firstW0), 512'(32'hFFFFC000));
    checkOutput("topLine0Word15", 512'(firstW15), 512'(32'hFFFFC03C));
    checkOutput("topLastIdx", 512'(lastPushLine), 512'(8'hFF));
    resetModel(18'h12345, 8'h00);
    @(posedge clk); #1;
    is_req = 1'b0;
    n = 0;
    while (pushCount == 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("newTagWord0", 512'(firstW0), 512'(32'h48D14000));
    checkOutput("newTagWord15", 512'(firstW15), 512'(32'h48D1403C));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);

`ifdef PROG_FILL_CRIT_FIRST_EN
    // Critical line first: order FE, FF, 00 ... FD.
    applyStimulus(18'h00777, 8'hFE);
    @(posedge clk); #1;
    is_req = 1'b0;
    waitFillDone(20000);
    @(negedge clk);
    checkOutput("critPushCount", 512'(pushCount), 512'(256));
    checkOutput("critFirstWord", 512'(firstW0), 512'({18'h00777, 8'hFE, 6'h00}));
    checkOutput("critLastIdx", 512'(lastPushLine), 512'(8'hFD));
    checkOutput("critDoneCount", 512'(doneCount), 512'(1));
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
